enable_window_gen: RTL
======================

# enable_window_gen

Multi-channel, parametrised enable-window generator for the PON datapath configuration path. Each channel turns a start pulse into a registered enable window with programmable start delay and length. It supports early stop, restart while running, and a repeat mode with a programmable gap. It replaces the single-channel count-until enable where several config consumers need independent, delayed or periodic enables from one clock domain.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- CNT_W, 32, width of delay/length/gap fields and internal counters
- clk_in  input  1  single system clock; all logic on rising edge
- resetn_in  input  1  synchronous, active-low reset
- start_in  input  NUM_CH  per-channel start pulse; config sampled on this cycle
- stop_in  input  NUM_CH  per-channel stop pulse; aborts the window
- delay_in  input  NUM_CH*CNT_W  cycles from start to the first enable cycle (ch i at [i*CNT_W +: CNT_W])
- length_in  input  NUM_CH*CNT_W  enable-high cycles per window
- gap_in  input  NUM_CH*CNT_W  low cycles between windows in repeat mode
- repeat_in  input  NUM_CH  1 = repeat windows until stop, 0 = one-shot
- enable_out  output  NUM_CH  registered per-channel enable
- busy_out  output  NUM_CH  channel is in DELAY, ACTIVE or GAP
- done_out  output  NUM_CH  one-cycle pulse when a channel returns to IDLE
- any_enable_out  output  1  registered OR of all enable_out bits

## Operation
- Per-channel FSM: IDLE, DELAY, ACTIVE, GAP. Each channel has its own down-counter (CNT_W bits) and shadow registers for delay/length/gap/repeat.
- Shadow registers load only on an accepted start. Input changes mid-window have no effect.
- Start is priority-ordered per channel:
  - resetn_in low beats stop_in.
  - stop_in beats start_in.
  - start_in beats the normal count.
- Start accepted (any state):
  - delay > 0 → DELAY.
  - delay = 0 and length > 0 → ACTIVE.
  - length = 0 → DELAY (if delay > 0), then straight to IDLE. Enable is never asserted and repeat is ignored.
- DELAY: counts down delay cycles, then goes to ACTIVE. If length = 0 it goes to IDLE instead.
- ACTIVE: enable_out = 1 for exactly length cycles. At the end:
  - repeat = 0 → IDLE.
  - repeat = 1, gap > 0 → GAP.
  - repeat = 1, gap = 0 → stays in ACTIVE with a reloaded count, so enable is continuous.
- GAP: enable_out = 0 for exactly gap cycles, then back to ACTIVE with length reloaded.
- Stop while busy → IDLE and done_out pulse. Stop while IDLE is ignored, with no done pulse.
- Start while busy restarts the channel from the new config. No done pulse for the aborted window.
- Counters never wrap. The maximum field value 2^CNT_W−1 gives exactly that many cycles.
- Channels are fully independent. Any combination of simultaneous starts and stops across channels is legal.

## Timing
- Reset (resetn_in low at an edge):
  - All FSMs → IDLE.
  - enable_out, busy_out, done_out, any_enable_out = 0 on the following cycle.
  - Reset mid-window aborts with no done pulse.
- Start sampled in cycle 0:
  - busy_out is high from cycle 1.
  - enable_out is high in cycles delay+1 through delay+length.
- One-shot end:
  - enable_out low in cycle delay+length+1.
  - done_out pulses in that same cycle and busy_out falls in that same cycle.
- length = 0: done_out pulses in cycle delay+1. busy_out is high for cycles 1..delay only; with delay = 0 it never rises.
- Repeat: the window period is length+gap cycles. The first window is placed as for one-shot.
- Stop sampled in cycle k: enable_out and busy_out are low in cycle k+1, and done_out pulses in cycle k+1.
- Start with stop in the same cycle: the stop is applied and the start is dropped.
- any_enable_out is registered from the next-state enables, so it is cycle-aligned with enable_out and adds no extra latency.

## Test plan
- Ch0 start, delay=0, length=5, repeat=0:
  - enable_out[0] high cycles 1–5.
  - done_out[0] pulse in cycle 6.
  - busy_out[0] high cycles 1–5.
  - Other channels stay 0.
- Ch1 start, delay=3, length=4, repeat=1, gap=2, stop in cycle 15:
  - enable high cycles 4–7 and 10–13, low 8–9 and 14–15.
  - Low from 16, done pulse in cycle 16.
- Ch2 start, delay=2, length=10; second start in cycle 5 with delay=0, length=3:
  - enable high cycles 3–5, then 6–8.
  - Single done pulse in cycle 9.
- Ch3 start and stop in the same cycle while IDLE: no enable, no busy, no done. Ch0 length=0, delay=2: done pulse in cycle 3, enable never high.
- Ch0 repeat=1, gap=0, length=2: enable continuously high from cycle 1. resetn_in low in cycle 20 → all outputs 0 in cycle 21 with no done pulse.
- All 4 channels started together with different delays: any_enable_out equals the OR of enable_out every cycle. Also check delay=2^CNT_W−1 with CNT_W=8: enable first rises in cycle 256.

Source files
------------

// File: rtl/enable_window_gen.sv
// Per-channel enable-window generator: a start pulse produces a delayed, optionally periodic enable window.
// Outputs are registered one cycle after the sampled start/stop. There is no backpressure: every pulse is acted on.
module enable_window_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    clk_in,
    input  logic                    resetn_in,
    input  logic [NUM_CH-1:0]       start_in,
    input  logic [NUM_CH-1:0]       stop_in,
    input  logic [NUM_CH*CNT_W-1:0] delay_in,
    input  logic [NUM_CH*CNT_W-1:0] length_in,
    input  logic [NUM_CH*CNT_W-1:0] gap_in,
    input  logic [NUM_CH-1:0]       repeat_in,
    output logic [NUM_CH-1:0]       enable_out,
    output logic [NUM_CH-1:0]       busy_out,
    output logic [NUM_CH-1:0]       done_out,
    output logic                    any_enable_out
);
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, GAP} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_CH-1:0] en_nxt;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] len_q, gap_q;
        logic             rpt_q;
        logic             done_d;
        logic             en_q, busy_q, done_q;
        logic [CNT_W-1:0] delay_i, length_i, gap_i;

        assign delay_i  = delay_in[ch*CNT_W +: CNT_W];
        assign length_i = length_in[ch*CNT_W +: CNT_W];
        assign gap_i    = gap_in[ch*CNT_W +: CNT_W];

        // The counter holds the remaining cycles of the current phase, so a count of 1 marks the last cycle.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
            if (stop_in[ch]) begin
                if (state_q != IDLE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else if (start_in[ch]) begin
                if (delay_i != '0) begin
                    state_d = DELAY;
                    cnt_d   = delay_i;
                end else if (length_i != '0) begin
                    state_d = ACTIVE;
                    cnt_d   = length_i;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                case (state_q)
                    DELAY: begin
                        if (cnt_q == ONE) begin
                            if (len_q != '0) begin
                                state_d = ACTIVE;
                                cnt_d   = len_q;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    ACTIVE: begin
                        if (cnt_q == ONE) begin
                            if (!rpt_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else if (gap_q != '0) begin
                                state_d = GAP;
                                cnt_d   = gap_q;
                            end else begin
                                cnt_d = len_q;
                            end
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    GAP: begin
                        if (cnt_q == ONE) begin
                            state_d = ACTIVE;
                            cnt_d   = len_q;
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk_in) begin
            if (!resetn_in) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                len_q   <= '0;
                gap_q   <= '0;
                rpt_q   <= 1'b0;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= (state_d == ACTIVE);
                busy_q  <= (state_d != IDLE);
                done_q  <= done_d;
                if (start_in[ch] && !stop_in[ch]) begin
                    len_q <= length_i;
                    gap_q <= gap_i;
                    rpt_q <= repeat_in[ch];
                end
            end
        end

        assign en_nxt[ch]     = (state_d == ACTIVE);
        assign enable_out[ch] = en_q;
        assign busy_out[ch]   = busy_q;
        assign done_out[ch]   = done_q;
    end

    // Registered from the next-state enables so it lines up with enable_out.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            any_enable_out <= 1'b0;
        end else begin
            any_enable_out <= |en_nxt;
        end
    end
endmodule
